load_store_unit: RTL and testbench

- Sits between the pipeline MEM stage and DataMemory.
- Accepts one load or store request at a time with RISC-V byte, halfword or word size. Checks alignment and issues word-wide MRd/MWrt accesses to DataMemory.
- Stores narrower than a word are performed as read-modify-write. Load results are returned sign- or zero-extended.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-wide load/store unit with alignment checks and byte/half read-modify-write
module load_store_unit #(
  parameter int WORD_ADDR  = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ,
  input  logic                  LD,
  input  logic                  ST,
  input  logic [2:0]            FUNCT3,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [31:0]           ST_DATA,
  output logic                  READY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [31:0]           LD_DATA,
  output logic                  MRd,
  output logic                  MWrt,
  output logic [ADDR_WIDTH-1:0] M_ADDR,
  output logic [31:0]           M_WDATA,
  input  logic [31:0]           R_DATA
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_CAP  = 3'd2,
    ST_WR   = 3'd3,
    RMW_RD  = 3'd4,
    RMW_CAP = 3'd5,
    RMW_WR  = 3'd6,
    FIN     = 3'd7
  } state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic                    done_q;
  logic                    err_q;
  logic                    mrd_q;
  logic                    mwrt_q;
  logic [31:0]             ld_data_q;
  logic [ADDR_WIDTH-1:0]   m_addr_q;
  logic [31:0]             m_wdata_q;
  logic [1:0]              lane_q;
  logic [2:0]              f3_q;
  logic [31:0]             st_data_q;

  logic                    bad_d;
  logic [ADDR_WIDTH-1:0]   word_addr_d;
  logic [31:0]             ld_ext_d;
  logic [31:0]             merged_d;

  // Decode the incoming request: legality of FUNCT3 for the operation plus natural alignment
  always_comb begin
    bad_d = 1'b0;
    if (LD && ST) begin
      bad_d = 1'b1;
    end else if (LD) begin
      bad_d = !(FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      bad_d = !(FUNCT3 inside {3'b000, 3'b001, 3'b010});
    end
    case (FUNCT3[1:0])
      2'b01:   if (ADDR[0])          bad_d = 1'b1;
      2'b10:   if (ADDR[1:0] != 2'b00) bad_d = 1'b1;
      default: ;
    endcase
  end

  // Memory-side address: either a word index or a byte address with the lane bits cleared
  always_comb begin
    word_addr_d = '0;
    if (WORD_ADDR != 0) begin
      word_addr_d = ADDR >> 2;
    end else begin
      word_addr_d = {ADDR[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  // Lane extraction with sign/zero extension for loads, and lane insertion for narrow stores
  always_comb begin
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] mask;
    logic [31:0] ins;
    byte_sh = R_DATA >> {lane_q, 3'b000};
    half_sh = R_DATA >> {lane_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ld_ext_d = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_ext_d = {24'h000000, byte_sh[7:0]};
      3'b001:  ld_ext_d = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_ext_d = {16'h0000, half_sh[15:0]};
      default: ld_ext_d = R_DATA;
    endcase
    if (f3_q[1:0] == 2'b01) begin
      mask = 32'h0000FFFF << {lane_q[1], 4'b0000};
      ins  = {16'h0000, st_data_q[15:0]} << {lane_q[1], 4'b0000};
    end else begin
      mask = 32'h000000FF << {lane_q, 3'b000};
      ins  = {24'h000000, st_data_q[7:0]} << {lane_q, 3'b000};
    end
    merged_d = (R_DATA & ~mask) | (ins & mask);
  end

  // Control FSM; every output is a register updated here, strobes default low each cycle
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mrd_q     <= 1'b0;
      mwrt_q    <= 1'b0;
      ld_data_q <= 32'h0;
      m_addr_q  <= '0;
      m_wdata_q <= 32'h0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
      st_data_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      mrd_q  <= 1'b0;
      mwrt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ && (LD || ST)) begin
            ready_q   <= 1'b0;
            lane_q    <= ADDR[1:0];
            f3_q      <= FUNCT3;
            st_data_q <= ST_DATA;
            m_addr_q  <= word_addr_d;
            err_q     <= bad_d;
            if (bad_d) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else if (LD) begin
              mrd_q   <= 1'b1;
              state_q <= LD_RD;
            end else if (FUNCT3[1:0] == 2'b10) begin
              mwrt_q    <= 1'b1;
              m_wdata_q <= ST_DATA;
              state_q   <= ST_WR;
            end else begin
              mrd_q   <= 1'b1;
              state_q <= RMW_RD;
            end
          end
        end
        LD_RD:   state_q <= LD_CAP;
        LD_CAP: begin
          ld_data_q <= ld_ext_d;
          done_q    <= 1'b1;
          state_q   <= FIN;
        end
        ST_WR: begin
          done_q  <= 1'b1;
          state_q <= FIN;
        end
        RMW_RD:  state_q <= RMW_CAP;
        RMW_CAP: begin
          m_wdata_q <= merged_d;
          mwrt_q    <= 1'b1;
          state_q   <= RMW_WR;
        end
        RMW_WR: begin
          done_q  <= 1'b1;
          state_q <= FIN;
        end
        FIN: begin
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign READY   = ready_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign LD_DATA = ld_data_q;
  assign MRd     = mrd_q;
  assign MWrt    = mwrt_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ, LD, ST;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR, ST_DATA;
  logic        READY, DONE, ERR, MRd, MWrt;
  logic [31:0] LD_DATA, M_ADDR, M_WDATA;
  logic [31:0] R_DATA;

  logic [31:0] mem [0:15];
  logic        init_mem;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          overlap  = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.WORD_ADDR(1), .ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LD(LD), .ST(ST), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .ST_DATA(ST_DATA), .READY(READY), .DONE(DONE), .ERR(ERR),
    .LD_DATA(LD_DATA), .MRd(MRd), .MWrt(MWrt), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .R_DATA(R_DATA)
  );

  // DataMemory model: one-cycle read latency, write on the strobe edge
  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
      R_DATA <= 32'h0;
    end else begin
      if (MRd)  R_DATA <= mem[M_ADDR[3:0]];
      if (MWrt) mem[M_ADDR[3:0]] <= M_WDATA;
    end
  end

  always @(negedge CLK) if (MRd && MWrt) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Masks are indexed by cycle number relative to the accept cycle (bit k = cycle k)
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [6:0] e_rd, input logic [6:0] e_wr, input logic [6:0] e_done,
                        input logic e_err, input logic [31:0] e_maddr, input logic [31:0] e_wdata,
                        input logic [31:0] e_ld);
    logic [6:0]  rd_m, wr_m, dn_m;
    logic [31:0] maddr1, maddr_last, wd, ldv;
    logic        errv;
    rd_m = '0; wr_m = '0; dn_m = '0;
    maddr1 = '0; maddr_last = '0; wd = '0; ldv = '0; errv = 1'b0;
    @(negedge CLK);
    REQ = 1'b1; LD = ld; ST = st; FUNCT3 = f3; ADDR = addr; ST_DATA = sdata;
    @(posedge CLK); #1;
    REQ = 1'b0; LD = 1'b0; ST = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      rd_m[k] = MRd; wr_m[k] = MWrt; dn_m[k] = DONE;
      if (k == 1) maddr1 = M_ADDR;
      if (DONE) begin errv = ERR; ldv = LD_DATA; maddr_last = M_ADDR; end
      if (MWrt) wd = M_WDATA;
    end
    check({tag, " done_cycle"}, {25'h0, dn_m}, {25'h0, e_done});
    check({tag, " err"}, {31'h0, errv}, {31'h0, e_err});
    check({tag, " mrd_cycles"}, {25'h0, rd_m}, {25'h0, e_rd});
    check({tag, " mwrt_cycles"}, {25'h0, wr_m}, {25'h0, e_wr});
    if ((e_rd | e_wr) != 7'h0) begin
      check({tag, " m_addr"}, maddr1, e_maddr);
      check({tag, " m_addr_hold"}, maddr_last, e_maddr);
    end
    if (e_wr != 7'h0) check({tag, " m_wdata"}, wd, e_wdata);
    if (ld) check({tag, " ld_data"}, ldv, e_ld);
    check({tag, " ready_after"}, {31'h0, READY}, 32'h1);
  endtask

  initial begin
    int wr_cnt, dn_cnt;
    RESET = 1'b0; REQ = 1'b0; LD = 1'b0; ST = 1'b0; FUNCT3 = 3'b000;
    ADDR = 32'h0; ST_DATA = 32'h0; init_mem = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst ready", {31'h0, READY}, 32'h1);
    check("rst done_err", {30'h0, DONE, ERR}, 32'h0);
    check("rst strobes", {30'h0, MRd, MWrt}, 32'h0);
    check("rst ld_data", LD_DATA, 32'h0);
    check("rst m_addr", M_ADDR, 32'h0);
    check("rst m_wdata", M_WDATA, 32'h0);
    RESET = 1'b1; init_mem = 1'b0;

    // REQ with neither LD nor ST must not start anything
    @(negedge CLK);
    REQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h14;
    @(posedge CLK); #1; REQ = 1'b0;
    @(negedge CLK);
    check("nop ready", {31'h0, READY}, 32'h1);
    check("nop quiet", {29'h0, DONE, MRd, MWrt}, 32'h0);

    run_op("LB 0x15",  1, 0, 3'b000, 32'h15, 32'h0, 7'b0000010, 7'b0, 7'b0001000, 0, 32'd5, 32'h0, 32'hFFFFFFAA);
    run_op("LHU 0x16", 1, 0, 3'b101, 32'h16, 32'h0, 7'b0000010, 7'b0, 7'b0001000, 0, 32'd5, 32'h0, 32'h00008899);
    run_op("LW 0x14",  1, 0, 3'b010, 32'h14, 32'h0, 7'b0000010, 7'b0, 7'b0001000, 0, 32'd5, 32'h0, 32'h8899AABB);

    // SH abandoned by reset in RMW_CAP; a stray REQ while busy must be ignored
    @(negedge CLK);
    REQ = 1'b1; LD = 1'b0; ST = 1'b1; FUNCT3 = 3'b001; ADDR = 32'h14; ST_DATA = 32'h5555;
    @(posedge CLK); #1; REQ = 1'b0; ST = 1'b0;
    @(negedge CLK);
    check("rstmid mrd", {31'h0, MRd}, 32'h1);
    REQ = 1'b1; ST = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h14; ST_DATA = 32'h0;
    @(negedge CLK);
    REQ = 1'b0; ST = 1'b0; RESET = 1'b0;
    @(posedge CLK); #1; RESET = 1'b1;
    wr_cnt = 0; dn_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (MWrt) wr_cnt++;
      if (DONE) dn_cnt++;
    end
    check("rstmid mwrt_count", wr_cnt, 0);
    check("rstmid done_count", dn_cnt, 0);
    check("rstmid ready", {31'h0, READY}, 32'h1);
    check("rstmid ld_data", LD_DATA, 32'h0);
    check("rstmid word5", mem[5], 32'h8899AABB);

    run_op("SW 0x20",  0, 1, 3'b010, 32'h20, 32'hDEADBEEF, 7'b0, 7'b0000010, 7'b0000100, 0, 32'd8, 32'hDEADBEEF, 32'h0);
    run_op("SB 0x17",  0, 1, 3'b000, 32'h17, 32'h12345677, 7'b0000010, 7'b0001000, 7'b0010000, 0, 32'd5, 32'h7799AABB, 32'h0);
    run_op("LW2 0x14", 1, 0, 3'b010, 32'h14, 32'h0, 7'b0000010, 7'b0, 7'b0001000, 0, 32'd5, 32'h0, 32'h7799AABB);
    run_op("SH 0x16",  0, 1, 3'b001, 32'h16, 32'h0000CAFE, 7'b0000010, 7'b0001000, 7'b0010000, 0, 32'd5, 32'hCAFEAABB, 32'h0);
    run_op("LH 0x16",  1, 0, 3'b001, 32'h16, 32'h0, 7'b0000010, 7'b0, 7'b0001000, 0, 32'd5, 32'h0, 32'hFFFFCAFE);
    run_op("LW 0x22 err", 1, 0, 3'b010, 32'h22, 32'h0, 7'b0, 7'b0, 7'b0000010, 1, 32'h0, 32'h0, 32'hFFFFCAFE);
    run_op("SH 0x13 err", 0, 1, 3'b001, 32'h13, 32'h0, 7'b0, 7'b0, 7'b0000010, 1, 32'h0, 32'h0, 32'h0);
    run_op("SB f3=100 err", 0, 1, 3'b100, 32'h10, 32'h0, 7'b0, 7'b0, 7'b0000010, 1, 32'h0, 32'h0, 32'h0);
    run_op("LD+ST err", 1, 1, 3'b010, 32'h14, 32'h0, 7'b0, 7'b0, 7'b0000010, 1, 32'h0, 32'h0, 32'hFFFFCAFE);

    check("mem word8", mem[8], 32'hDEADBEEF);
    check("mem word5", mem[5], 32'hCAFEAABB);
    check("strobe overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
